// File: rtl/exe_pkg.sv
// Shared types for the execution unit and its result buffer: default widths,
// status code and the result entry layout.
package exe_pkg;

  localparam int EXE_M = 4;
  localparam int EXE_N = 2;

  typedef logic [1:0] status_t;

  localparam status_t ST_OK = 2'b00;

  typedef struct packed {
    logic [EXE_M-1:0] result;
    status_t          status;
    logic [EXE_N-1:0] oper;
  } exe_entry_t;

endpackage

// File: rtl/exe_buf_ptr.sv
// Wrapping buffer pointer with one extra wrap bit; increments on i_inc,
// returns to zero on i_clr (synchronous) or i_rsn (asynchronous, active-high).
module exe_buf_ptr #(
  parameter int W = 3
) (
  input  logic         i_clk,
  input  logic         i_rsn,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_ptr
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge i_clk or posedge i_rsn) begin
    if (i_rsn) begin
      o_ptr <= '0;
    end else if (i_clr) begin
      o_ptr <= '0;
    end else if (i_inc) begin
      o_ptr <= o_ptr + W'(1);
    end
  end

endmodule

// File: rtl/exe_result_buf.sv
// FIFO buffer between the execution unit and its consumer, with sticky error
// flag. Define EXE_RESULT_BUF_CNT_EN to add the saturating o_errcnt output.
module exe_result_buf
  import exe_pkg::*;
#(
  parameter int M     = EXE_M,
  parameter int N     = EXE_N,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rsn,
  input  logic                       i_valid,
  input  logic [M-1:0]               i_result,
  input  logic [1:0]                 i_status,
  input  logic [N-1:0]               i_oper,
  output logic                       o_ready,
  output logic                       o_valid,
  output logic [M-1:0]               o_result,
  output logic [1:0]                 o_status,
  output logic [N-1:0]               o_oper,
  input  logic                       i_ready,
  input  logic                       i_clr,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty,
`ifdef EXE_RESULT_BUF_CNT_EN
  output logic                       o_err,
  output logic [7:0]                 o_errcnt
`else
  output logic                       o_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic [M-1:0] result;
    status_t      status;
    logic [N-1:0] oper;
  } entry_t;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;
  logic          bad_status;
  entry_t        mem [DEPTH];
  entry_t        head;

  // Flush wins over any transfer in the same cycle.
  assign wr_en      = i_valid && o_ready && !i_clr;
  assign rd_en      = o_valid && i_ready && !i_clr;
  assign bad_status = (i_status != ST_OK);

  exe_buf_ptr #(.W(PW)) u_tail (
    .i_clk (i_clk),
    .i_rsn (i_rsn),
    .i_inc (wr_en),
    .i_clr (i_clr),
    .o_ptr (wr_ptr)
  );

  exe_buf_ptr #(.W(PW)) u_head (
    .i_clk (i_clk),
    .i_rsn (i_rsn),
    .i_inc (rd_en),
    .i_clr (i_clr),
    .o_ptr (rd_ptr)
  );

  // NOTE: storage has no reset; validity is tracked entirely by the pointers,
  // which lets the array map onto plain RAM/regfile cells.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= '{result: i_result, status: i_status, oper: i_oper};
    end
  end

  // Flags come from registered pointers only; i_ready never reaches o_ready.
  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign o_count = wr_ptr - rd_ptr;
  assign o_ready = !o_full;
  assign o_valid = !o_empty;

  assign head     = mem[rd_ptr[AW-1:0]];
  assign o_result = head.result;
  assign o_status = head.status;
  assign o_oper   = head.oper;

  always_ff @(posedge i_clk or posedge i_rsn) begin
    if (i_rsn) begin
      o_err <= 1'b0;
    end else if (i_clr) begin
      o_err <= 1'b0;
    end else if (wr_en && bad_status) begin
      o_err <= 1'b1;
    end
  end

`ifdef EXE_RESULT_BUF_CNT_EN
  always_ff @(posedge i_clk or posedge i_rsn) begin
    if (i_rsn) begin
      o_errcnt <= '0;
    end else if (i_clr) begin
      o_errcnt <= '0;
    end else if (wr_en && bad_status && (o_errcnt != 8'hFF)) begin
      o_errcnt <= o_errcnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_exe_result_buf.sv
// Directed self-checking bench for exe_result_buf (M=4, N=2, DEPTH=4).
module tb_exe_result_buf;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_result;
  logic [1:0] in_status;
  logic [1:0] in_oper;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] out_result;
  logic [1:0] out_status;
  logic [1:0] out_oper;
  logic       in_ready;
  logic       clr;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       err;
`ifdef EXE_RESULT_BUF_CNT_EN
  logic [7:0] errcnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  exe_result_buf #(.M(4), .N(2), .DEPTH(4)) dut (
    .i_clk    (clk),
    .i_rsn    (rst),
    .i_valid  (in_valid),
    .i_result (in_result),
    .i_status (in_status),
    .i_oper   (in_oper),
    .o_ready  (out_ready),
    .o_valid  (out_valid),
    .o_result (out_result),
    .o_status (out_status),
    .o_oper   (out_oper),
    .i_ready  (in_ready),
    .i_clr    (clr),
    .o_count  (count),
    .o_full   (full),
    .o_empty  (empty),
`ifdef EXE_RESULT_BUF_CNT_EN
    .o_err    (err),
    .o_errcnt (errcnt)
`else
    .o_err    (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] r, input logic [1:0] s,
                       input logic [1:0] o, input logic rdy);
    in_valid  = v;
    in_result = r;
    in_status = s;
    in_oper   = o;
    in_ready  = rdy;
  endtask

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    drive(1'b0, 4'h0, 2'b00, 2'b00, 1'b0);
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full",  32'(full),  32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(out_ready), 32'd1);
    check("rst_err",   32'(err),   32'd0);
    #12 rst = 1'b0;
    tick();

    // Single write, one-cycle latency, no bypass.
    drive(1'b1, 4'h3, 2'b00, 2'b01, 1'b0);
    #1;
    check("nobypass_valid", 32'(out_valid), 32'd0);
    tick();
    drive(1'b0, 4'h0, 2'b00, 2'b00, 1'b0);
    check("lat_valid",  32'(out_valid),  32'd1);
    check("lat_result", 32'(out_result), 32'h3);
    check("lat_oper",   32'(out_oper),   32'h1);
    check("lat_count",  32'(count),      32'd1);
    check("lat_err",    32'(err),        32'd0);
    in_ready = 1'b1;
    tick();
    check("drain1_empty", 32'(empty), 32'd1);
    tick();  // i_ready while empty
    check("empty_rdy_count", 32'(count), 32'd0);
    check("empty_rdy_valid", 32'(out_valid), 32'd0);

    // Fill to full, refuse a fifth write.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 4'(i), 2'b00, 2'b10, 1'b0);
      tick();
    end
    check("fill_full",  32'(full),      32'd1);
    check("fill_ready", 32'(out_ready), 32'd0);
    check("fill_count", 32'(count),     32'd4);
    drive(1'b1, 4'h5, 2'b00, 2'b10, 1'b0);
    tick();
    check("refuse_count", 32'(count), 32'd4);
    check("refuse_head",  32'(out_result), 32'h1);

    // Full with simultaneous valid/ready: read proceeds, write refused.
    drive(1'b1, 4'h5, 2'b00, 2'b10, 1'b1);
    tick();
    drive(1'b0, 4'h0, 2'b00, 2'b00, 1'b1);
    check("fullrw_count", 32'(count),     32'd3);
    check("fullrw_ready", 32'(out_ready), 32'd1);
    for (int i = 2; i <= 4; i++) begin
      check($sformatf("drain_%0d", i), 32'(out_result), 32'(i));
      tick();
    end
    check("drain_empty", 32'(empty), 32'd1);

    // Streaming: count stays at 1, order preserved across wraps.
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 4'(k), 2'b00, 2'(k), 1'b1);
      tick();
      check($sformatf("stream_res_%0d", k), 32'(out_result), 32'(k));
      check($sformatf("stream_cnt_%0d", k), 32'(count), 32'd1);
    end
    drive(1'b0, 4'h0, 2'b00, 2'b00, 1'b1);
    tick();
    check("stream_empty", 32'(empty), 32'd1);

    // Sticky error and flush overriding a transfer.
    drive(1'b1, 4'h7, 2'b01, 2'b11, 1'b0);
    tick();
    check("err_set", 32'(err), 32'd1);
`ifdef EXE_RESULT_BUF_CNT_EN
    check("errcnt_one", 32'(errcnt), 32'd1);
`endif
    drive(1'b1, 4'h8, 2'b00, 2'b00, 1'b1);
    tick();
    drive(1'b0, 4'h0, 2'b00, 2'b00, 1'b1);
    check("err_rw_head", 32'(out_result), 32'h8);
    tick();
    check("err_drained_empty", 32'(empty), 32'd1);
    check("err_hold", 32'(err), 32'd1);
    drive(1'b1, 4'h9, 2'b00, 2'b00, 1'b0);
    tick();
    drive(1'b1, 4'hB, 2'b10, 2'b00, 1'b1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    drive(1'b0, 4'h0, 2'b00, 2'b00, 1'b0);
    check("clr_count", 32'(count), 32'd0);
    check("clr_err",   32'(err),   32'd0);
    check("clr_empty", 32'(empty), 32'd1);
`ifdef EXE_RESULT_BUF_CNT_EN
    check("errcnt_clr", 32'(errcnt), 32'd0);
`endif

    // Asynchronous reset mid-operation.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'hC + 4'(i), 2'b01, 2'b00, 1'b0);
      tick();
    end
    drive(1'b0, 4'h0, 2'b00, 2'b00, 1'b0);
    check("pre_rst_count", 32'(count), 32'd3);
    #3 rst = 1'b1;
    #1;
    check("async_valid", 32'(out_valid), 32'd0);
    check("async_count", 32'(count),     32'd0);
    check("async_err",   32'(err),       32'd0);
    #2 rst = 1'b0;
    drive(1'b1, 4'hA, 2'b00, 2'b01, 1'b0);
    tick();
    drive(1'b1, 4'h5, 2'b00, 2'b10, 1'b1);
    check("post_rst_head",  32'(out_result), 32'hA);
    check("post_rst_count", 32'(count),      32'd1);
    tick();
    drive(1'b0, 4'h0, 2'b00, 2'b00, 1'b1);
    check("post_rst_second", 32'(out_result), 32'h5);
    tick();
    check("post_rst_empty", 32'(empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
